// File: rtl/datamem_responder.sv
// Data-memory responder for the MEM stage: word/halfword/byte stores go
// through a one-entry write buffer that reads bypass, and one word address
// is a memory-mapped output register.
module datamem_responder #(
  parameter int unsigned          ADDR_W    = 7,
  parameter logic [ADDR_W-1:0]    MMIO_ADDR = 7'h7F,
  parameter int unsigned          CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] datamem_rd_addr0,
  output logic [31:0]       datamem_rd_dout0,
  input  logic [ADDR_W-1:0] datamem_wr_addr0,
  input  logic [31:0]       datamem_wr_din0,
  input  logic              datamem_we0,
  input  logic [2:0]        datamem_wr_strb,
  output logic [31:0]       mmio_out,
  output logic              mmio_stb,
  output logic              strb_err,
  output logic [CNT_W-1:0]  wr_count
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [31:0]       mem_q [DEPTH];

  logic              pend_valid_q, pend_valid_d;
  logic [ADDR_W-1:0] pend_addr_q,  pend_addr_d;
  logic [3:0]        pend_mask_q,  pend_mask_d;
  logic [31:0]       pend_data_q,  pend_data_d;
  logic [31:0]       mmio_out_q,   mmio_out_d;
  logic              mmio_stb_q,   mmio_stb_d;
  logic              strb_err_q,   strb_err_d;
  logic [CNT_W-1:0]  wr_count_q,   wr_count_d;

  logic [3:0]        st_mask;
  logic [31:0]       st_data;
  logic              st_legal;
  logic              st_accept;
  logic              st_mmio;
  logic [31:0]       commit_word;
  logic [31:0]       mmio_merged;

  // Strobe decode into a lane mask and lane-aligned store data
  always_comb begin
    st_mask  = '0;
    st_data  = '0;
    st_legal = 1'b1;
    case (datamem_wr_strb)
      3'b000: begin
        st_mask = 4'b1111;
        st_data = datamem_wr_din0;
      end
      3'b001: begin
        st_mask = 4'b0011;
        st_data = {16'h0000, datamem_wr_din0[15:0]};
      end
      3'b011: begin
        st_mask = 4'b1100;
        st_data = {datamem_wr_din0[15:0], 16'h0000};
      end
      3'b010: st_legal = 1'b0;
      default: begin
        st_mask = 4'b0001 << datamem_wr_strb[1:0];
        st_data = {4{datamem_wr_din0[7:0]}};
      end
    endcase
  end

  assign st_accept = datamem_we0 && st_legal;
  assign st_mmio   = (datamem_wr_addr0 == MMIO_ADDR);

  // Byte-lane merges: buffered entry into its array word, new store into mmio
  always_comb begin
    commit_word = mem_q[pend_addr_q];
    mmio_merged = mmio_out_q;
    for (int unsigned l = 0; l < 4; l++) begin
      if (pend_mask_q[l]) commit_word[8*l +: 8] = pend_data_q[8*l +: 8];
      if (st_mask[l])     mmio_merged[8*l +: 8] = st_data[8*l +: 8];
    end
  end

  // Next-state for buffer, MMIO register, error flag and store counter
  always_comb begin
    pend_valid_d = 1'b0;
    pend_addr_d  = pend_addr_q;
    pend_mask_d  = pend_mask_q;
    pend_data_d  = pend_data_q;
    mmio_out_d   = mmio_out_q;
    mmio_stb_d   = 1'b0;
    strb_err_d   = strb_err_q | (datamem_we0 && !st_legal);
    wr_count_d   = wr_count_q;
    if (st_accept) begin
      if (wr_count_q != '1) wr_count_d = wr_count_q + 1'b1;
      if (st_mmio) begin
        mmio_out_d = mmio_merged;
        mmio_stb_d = 1'b1;
      end else begin
        pend_valid_d = 1'b1;
        pend_addr_d  = datamem_wr_addr0;
        pend_mask_d  = st_mask;
        pend_data_d  = st_data;
      end
    end
  end

  // Control/status registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      pend_mask_q  <= '0;
      pend_data_q  <= '0;
      mmio_out_q   <= '0;
      mmio_stb_q   <= 1'b0;
      strb_err_q   <= 1'b0;
      wr_count_q   <= '0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      pend_mask_q  <= pend_mask_d;
      pend_data_q  <= pend_data_d;
      mmio_out_q   <= mmio_out_d;
      mmio_stb_q   <= mmio_stb_d;
      strb_err_q   <= strb_err_d;
      wr_count_q   <= wr_count_d;
    end
  end

  // Array: commits the buffered entry on the edge after capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (pend_valid_q) begin
      mem_q[pend_addr_q] <= commit_word;
    end
  end

  // Read path: MMIO register, or array word with pending lanes bypassed
  always_comb begin
    datamem_rd_dout0 = mem_q[datamem_rd_addr0];
    if (datamem_rd_addr0 == MMIO_ADDR) begin
      datamem_rd_dout0 = mmio_out_q;
    end else if (pend_valid_q && (pend_addr_q == datamem_rd_addr0)) begin
      for (int unsigned l = 0; l < 4; l++)
        if (pend_mask_q[l]) datamem_rd_dout0[8*l +: 8] = pend_data_q[8*l +: 8];
    end
  end

  assign mmio_out = mmio_out_q;
  assign mmio_stb = mmio_stb_q;
  assign strb_err = strb_err_q;
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_datamem_responder.sv
// Bench for datamem_responder: a byte-level memory model predicts reads,
// expected read data goes through a scoreboard queue.
module tb_datamem_responder;

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned CNT_W  = 4;
  localparam logic [ADDR_W-1:0] MMIO = 7'h7F;

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] rd_addr;
  logic [31:0]       rd_dout;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_din;
  logic              we0;
  logic [2:0]        wr_strb;
  logic [31:0]       mmio_out;
  logic              mmio_stb;
  logic              strb_err;
  logic [CNT_W-1:0]  wr_count;

  datamem_responder #(
    .ADDR_W    (ADDR_W),
    .MMIO_ADDR (MMIO),
    .CNT_W     (CNT_W)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .datamem_rd_addr0 (rd_addr),
    .datamem_rd_dout0 (rd_dout),
    .datamem_wr_addr0 (wr_addr),
    .datamem_wr_din0  (wr_din),
    .datamem_we0      (we0),
    .datamem_wr_strb  (wr_strb),
    .mmio_out         (mmio_out),
    .mmio_stb         (mmio_stb),
    .strb_err         (strb_err),
    .wr_count         (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model
  logic [31:0]      m_mem [128];
  logic [31:0]      m_mmio;
  logic             m_stb;
  logic             m_err;
  logic [CNT_W-1:0] m_cnt;

  logic [31:0] exp_q [$];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 128; i++) m_mem[i] = '0;
    m_mmio = '0;
    m_stb  = 1'b0;
    m_err  = 1'b0;
    m_cnt  = '0;
  endtask

  function automatic logic [31:0] model_rd(input logic [ADDR_W-1:0] a);
    return (a == MMIO) ? m_mmio : m_mem[a];
  endfunction

  task automatic model_store(input logic [ADDR_W-1:0] a, input logic [31:0] d,
                             input logic [2:0] s);
    logic [31:0] w;
    logic        ok;
    int          lane;
    w  = model_rd(a);
    ok = 1'b1;
    case (s)
      3'b000: w = d;
      3'b001: w[15:0] = d[15:0];
      3'b011: w[31:16] = d[15:0];
      3'b010: ok = 1'b0;
      default: begin
        lane = int'(s[1:0]);
        w[8*lane +: 8] = d[7:0];
      end
    endcase
    m_stb = 1'b0;
    if (!ok) begin
      m_err = 1'b1;
    end else begin
      if (m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
      if (a == MMIO) begin
        m_mmio = w;
        m_stb  = 1'b1;
      end else begin
        m_mem[a] = w;
      end
    end
  endtask

  task automatic check_status(input string where);
    check({where, ".mmio_out"}, mmio_out, m_mmio);
    check({where, ".mmio_stb"}, {31'b0, mmio_stb}, {31'b0, m_stb});
    check({where, ".strb_err"}, {31'b0, strb_err}, {31'b0, m_err});
    check({where, ".wr_count"}, {28'b0, wr_count}, {28'b0, m_cnt});
  endtask

  // One cycle: drive a store and read the same address (pre-edge data expected)
  task automatic store(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [2:0] s);
    logic [31:0] e;
    @(negedge clk);
    we0 = 1'b1; wr_addr = a; wr_din = d; wr_strb = s; rd_addr = a;
    exp_q.push_back(model_rd(a));
    #1;
    e = exp_q.pop_front();
    check("rd_same_cycle", rd_dout, e);
    @(posedge clk);
    #1;
    model_store(a, d, s);
    we0 = 1'b0;
    check_status("store");
  endtask

  // One idle cycle with a read
  task automatic read(input logic [ADDR_W-1:0] a);
    logic [31:0] e;
    @(negedge clk);
    we0 = 1'b0; rd_addr = a;
    exp_q.push_back(model_rd(a));
    #1;
    e = exp_q.pop_front();
    check("rd", rd_dout, e);
    @(posedge clk);
    #1;
    m_stb = 1'b0;
    check("idle.mmio_stb", {31'b0, mmio_stb}, {31'b0, m_stb});
  endtask

  initial begin
    logic [ADDR_W-1:0] ra;
    logic [ADDR_W-1:0] addrs [10];
    rst = 1'b0; we0 = 1'b0; wr_addr = '0; wr_din = '0; wr_strb = '0; rd_addr = '0;
    model_reset();

    // reset state
    #2;
    addrs[0] = 7'd0; addrs[1] = 7'd5; addrs[2] = 7'd127;
    for (int i = 0; i < 3; i++) begin
      rd_addr = addrs[i];
      #1;
      check("reset_rd", rd_dout, 32'h0);
    end
    check_status("reset");
    #9;
    rst = 1'b1;

    // word store, bypass read then array read
    store(7'd3, 32'hDEADBEEF, 3'b000);
    read(7'd3);
    read(7'd3);
    read(7'd3);

    // byte lane 2 then low halfword, back to back on the same word
    store(7'd3, 32'h000000AA, 3'b110);
    store(7'd3, 32'h00001234, 3'b001);
    read(7'd3);
    check("merge_literal", rd_dout, 32'hDEAA1234);
    read(7'd3);

    // illegal strobe
    store(7'd4, 32'hFFFFFFFF, 3'b010);
    read(7'd4);
    read(7'd4);
    check("err_sticky", {31'b0, strb_err}, 32'd1);

    // MMIO store: strobe high for one cycle, then falls
    store(MMIO, 32'h00000055, 3'b000);
    check("mmio_literal", mmio_out, 32'h55);
    read(MMIO);
    read(MMIO);

    // reset while a store is still buffered
    store(7'd9, 32'h11111111, 3'b000);
    rst = 1'b0;
    model_reset();
    #1;
    check_status("midreset");
    rst = 1'b1;
    read(7'd9);
    read(7'd9);

    // random mix; counter saturates with CNT_W=4
    for (int i = 0; i < 10; i++) addrs[i] = 7'(i);
    addrs[8] = MMIO;
    addrs[9] = 7'd126;
    for (int i = 0; i < 60; i++) begin
      ra = addrs[$urandom_range(0, 9)];
      store(ra, $urandom, 3'($urandom_range(0, 7)));
      if ($urandom_range(0, 1) == 1) read(addrs[$urandom_range(0, 9)]);
    end
    for (int i = 0; i < 10; i++) read(addrs[i]);
    check("cnt_saturated", {28'b0, wr_count}, 32'd15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
